// File: rtl/lfsr_decrypt_engine.sv
// LFSR-XOR message decryptor.
// Recovers the seed and tap pattern from the all-space preamble of a
// 64-byte cipher block in data memory. The plaintext is then written back to
// the bottom of data memory. The memory port is shared with the MISC core.
module lfsr_decrypt_engine #(
    parameter int FIXED_PRE   = 9,
    parameter int MSG_LEN     = 41,
    parameter int CIPHER_BASE = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       strip_lead,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] taps_idx
);

    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] PRE8   = 8'(FIXED_PRE);
    localparam logic [7:0] LEN8   = 8'(MSG_LEN);
    localparam logic [7:0] BASE8  = 8'(CIPHER_BASE);
    localparam logic [7:0] LAST_K = 8'd63;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEARCH, S_DEC_RD, S_DEC_WR, S_PAD, S_DONE
    } state_t;

    function automatic logic [7:0] tap_of(input logic [2:0] i);
        case (i)
            3'd0:    tap_of = 8'hE1;
            3'd1:    tap_of = 8'hD4;
            3'd2:    tap_of = 8'hC6;
            3'd3:    tap_of = 8'hB8;
            3'd4:    tap_of = 8'hB4;
            3'd5:    tap_of = 8'hB2;
            3'd6:    tap_of = 8'hFA;
            default: tap_of = 8'hF3;
        endcase
    endfunction

    // Plain Fibonacci shift: an all-zero state stays zero forever.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] t);
        lfsr_step = {s[6:0], ^(s & t)};
    endfunction

    state_t     state;
    logic       mode;        // latched strip_lead
    logic [7:0] cbuf [0:8];  // preamble cipher bytes c[0..8]
    logic [3:0] cnt;         // LOAD beat / SEARCH step number
    logic [2:0] idx;         // candidate tap pattern
    logic [7:0] lfsr;
    logic [7:0] k;           // cipher index during DECRYPT
    logic [7:0] waddr;       // next plaintext address
    logic       started;     // mode 1: first non-space byte already seen

    logic [7:0] seed;
    logic [7:0] lfsr_nx;
    logic [7:0] dec_p;
    logic       dec_keep;
    logic [7:0] waddr_nx;

    assign seed     = cbuf[0] ^ SPACE;
    assign lfsr_nx  = lfsr_step(lfsr, tap_of(idx));
    assign dec_p    = mem_rdata ^ lfsr;
    assign dec_keep = mode ? (started || (dec_p != SPACE)) : (k >= PRE8);
    assign waddr_nx = waddr + {7'd0, dec_keep};

    // Write strobe and data come straight from the read data of the same
    // cycle, which keeps each byte to one read slot and one write slot.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (!reset) begin
            if (state == S_DEC_WR) begin
                mem_we    = dec_keep;
                mem_wdata = dec_p;
            end else if (state == S_PAD) begin
                mem_we    = 1'b1;
                mem_wdata = SPACE;
            end
        end
    end

    // Capture the preamble bytes as their reads return.
    always_ff @(posedge clk) begin
        // NOTE: the preamble buffer is pure data, always refilled before use, so it has no reset.
        if (state == S_LOAD && cnt != 4'd0)
            cbuf[cnt - 4'd1] <= mem_rdata;
    end

    // Main controller: load, tap search, decrypt, pad, done.
    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state    <= S_IDLE;
            mode     <= 1'b0;
            cnt      <= 4'd0;
            idx      <= 3'd0;
            lfsr     <= 8'h00;
            k        <= 8'h00;
            waddr    <= 8'h00;
            started  <= 1'b0;
            mem_addr <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            taps_idx <= 3'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode     <= strip_lead;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        taps_idx <= 3'd0;
                        cnt      <= 4'd0;
                        mem_addr <= BASE8;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Nine reads at cnt 0..8; cnt 9 only collects the last byte.
                    if (cnt == 4'd9) begin
                        cnt   <= 4'd1;
                        idx   <= 3'd0;
                        lfsr  <= seed;
                        state <= S_SEARCH;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt < 4'd8)
                            mem_addr <= mem_addr + 8'd1;
                    end
                end
                S_SEARCH: begin
                    if (cbuf[cnt] != (lfsr_nx ^ SPACE)) begin
                        if (idx == 3'd7) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            idx  <= idx + 3'd1;
                            lfsr <= seed;
                            cnt  <= 4'd1;
                        end
                    end else if (cnt == 4'd8) begin
                        taps_idx <= idx;
                        lfsr     <= seed;
                        k        <= 8'h00;
                        waddr    <= 8'h00;
                        started  <= 1'b0;
                        mem_addr <= BASE8;
                        state    <= S_DEC_RD;
                    end else begin
                        lfsr <= lfsr_nx;
                        cnt  <= cnt + 4'd1;
                    end
                end
                S_DEC_RD: begin
                    mem_addr <= waddr;
                    state    <= S_DEC_WR;
                end
                S_DEC_WR: begin
                    started <= started | dec_keep;
                    waddr   <= waddr_nx;
                    if (waddr_nx == LEN8) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (k == LAST_K) begin
                        if (mode) begin
                            mem_addr <= waddr_nx;
                            state    <= S_PAD;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end
                    end else begin
                        k        <= k + 8'd1;
                        lfsr     <= lfsr_nx;
                        mem_addr <= BASE8 + k + 8'd1;
                        state    <= S_DEC_RD;
                    end
                end
                S_PAD: begin
                    if (mem_addr == LEN8 - 8'd1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        mem_addr <= mem_addr + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Self-checking bench for lfsr_decrypt_engine.
// A behavioural data memory serves the cipher block. A scoreboard queue
// holds the expected write stream, and each DUT write is popped and compared.
module tb_lfsr_decrypt_engine;

    localparam int MAX_LAT = 243;
    localparam logic [7:0] TAPS [0:7] = '{8'hE1, 8'hD4, 8'hC6, 8'hB8, 8'hB4, 8'hB2, 8'hFA, 8'hF3};
    localparam string MSG1 = "Knowledge comes, but wisdom lingers.     ";
    localparam string MSG2 = "    f     A joke is a very serious thing.";

    logic       clk = 1'b0;
    logic       reset, start, strip_lead;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, busy, done, error;
    logic [2:0] taps_idx;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q [$];
    logic [7:0] cipher  [0:63];
    logic [7:0] pt      [0:63];
    logic [7:0] exp_mem [0:40];
    logic [7:0] dm_lo   [0:63];
    logic       clr;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    lfsr_decrypt_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .strip_lead (strip_lead),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .taps_idx   (taps_idx)
    );

    // Data memory: 0..63 writable, 64..127 is the cipher block.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) dm_lo[i] <= 8'hEE;
        end else if (mem_we && mem_addr[7:6] == 2'b00) begin
            dm_lo[mem_addr[5:0]] <= mem_wdata;
        end
        mem_rdata <= (mem_addr[7:6] == 2'b01) ? cipher[mem_addr[5:0]] : dm_lo[mem_addr[5:0]];
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    task automatic build(input logic [7:0] seed, input logic [7:0] t, input int pre, input string msg);
        logic [7:0] s;
        for (int i = 0; i < 64; i++) begin
            if (i >= pre && (i - pre) < msg.len()) pt[i] = msg[i - pre];
            else                                   pt[i] = 8'h20;
        end
        s = seed;
        for (int i = 0; i < 64; i++) begin
            cipher[i] = pt[i] ^ s;
            s = lfsr_next(s, t);
        end
    endtask

    task automatic expect_writes(input bit mode, input bit err);
        wr_t w;
        int  f;
        int  a;
        exp_q.delete();
        for (int i = 0; i < 41; i++) exp_mem[i] = 8'hEE;
        if (!err) begin
            a = 0;
            if (!mode) begin
                f = 9;
            end else begin
                f = 64;
                for (int i = 63; i >= 0; i--) if (pt[i] != 8'h20) f = i;
            end
            for (int i = f; i < 64 && a < 41; i++) begin
                w.addr = 8'(a); w.data = pt[i];
                exp_q.push_back(w);
                exp_mem[a] = pt[i];
                a++;
            end
            while (a < 41) begin
                w.addr = 8'(a); w.data = 8'h20;
                exp_q.push_back(w);
                exp_mem[a] = 8'h20;
                a++;
            end
        end
    endtask

    task automatic clear_mem();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    // Scoreboard pop: called at each negedge while a run is in flight.
    task automatic sample_write(input string name);
        wr_t w;
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected_write got %h@%h required none", name, mem_wdata, mem_addr);
            end else begin
                w = exp_q.pop_front();
                if (mem_addr !== w.addr || mem_wdata !== w.data) begin
                    errors++;
                    $display("FAIL %s write got %h@%h required %h@%h", name, mem_wdata, mem_addr, w.data, w.addr);
                end
            end
        end
    endtask

    task automatic run(input string name, input bit mode, input bit exp_err,
                       input logic [2:0] exp_idx, input bit poke);
        int n;
        int bad;
        @(negedge clk);
        strip_lead = mode;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        strip_lead = ~mode;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 || taps_idx !== 3'd0) begin
            errors++;
            $display("FAIL %s after_start got busy=%b done=%b error=%b idx=%0d required 1 0 0 0",
                     name, busy, done, error, taps_idx);
        end
        sample_write(name);
        n = 0;
        while (done !== 1'b1 && n < MAX_LAT + 20) begin
            @(negedge clk);
            n++;
            if (poke) begin
                if (n == 30)      start = 1'b1;
                else if (n == 31) start = 1'b0;
            end
            sample_write(name);
        end
        checks++;
        if (done !== 1'b1 || n > MAX_LAT) begin
            errors++;
            $display("FAIL %s latency got %0d cycles done=%b required <= %0d", name, n, done, MAX_LAT);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done got %b required 0", name, busy);
        end
        checks++;
        if (error !== exp_err) begin
            errors++;
            $display("FAIL %s error got %b required %b", name, error, exp_err);
        end
        if (!exp_err) begin
            checks++;
            if (taps_idx !== exp_idx) begin
                errors++;
                $display("FAIL %s taps_idx got %0d required %0d", name, taps_idx, exp_idx);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes got %0d left required 0", name, exp_q.size());
        end
        @(negedge clk);
        sample_write(name);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_level got done=%b busy=%b required 1 0", name, done, busy);
        end
        bad = -1;
        for (int i = 40; i >= 0; i--) if (dm_lo[i] !== exp_mem[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s dm[%0d] got %h required %h", name, bad, dm_lo[bad], exp_mem[bad]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; strip_lead = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_addr, mem_we, mem_wdata, busy, done, error, taps_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h we=%b wd=%h busy=%b done=%b err=%b idx=%0d required all 0",
                     mem_addr, mem_we, mem_wdata, busy, done, error, taps_idx);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_we, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_outputs got we=%b busy=%b done=%b required 0 0 0", mem_we, busy, done);
        end
    endtask

    task automatic test_mode0_fixed();
        build(8'h5A, 8'hB8, 9, MSG1);
        expect_writes(1'b0, 1'b0);
        clear_mem();
        run("t1_mode0", 1'b0, 1'b0, 3'd3, 1'b1);
    endtask

    task automatic test_mode1_strip();
        build(8'h4B, 8'hB2, 13, MSG2);
        expect_writes(1'b1, 1'b0);
        clear_mem();
        run("t2_mode1", 1'b1, 1'b0, 3'd5, 1'b0);
    endtask

    task automatic test_mode1_all_space();
        build(8'h01, 8'hE1, 64, "");
        expect_writes(1'b1, 1'b0);
        clear_mem();
        run("mode1_all_space", 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_all_taps();
        for (int i = 0; i < 8; i++) begin
            build(8'h01, TAPS[i], 9, MSG1);
            expect_writes(1'b0, 1'b0);
            clear_mem();
            run($sformatf("t3_taps%0d", i), 1'b0, 1'b0, 3'(i), 1'b0);
        end
    endtask

    task automatic test_no_match();
        build(8'h5A, 8'hB8, 9, MSG1);
        cipher[5] = cipher[5] ^ 8'h01;
        expect_writes(1'b0, 1'b1);
        clear_mem();
        run("t4_no_match", 1'b0, 1'b1, 3'd0, 1'b0);
    endtask

    task automatic test_zero_seed();
        build(8'h00, 8'hB8, 9, MSG1);
        expect_writes(1'b0, 1'b0);
        clear_mem();
        run("t5_zero_seed", 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int  n;
        int  wr_after;
        bit  seen;
        build(8'h5A, 8'hB8, 9, MSG1);
        expect_writes(1'b0, 1'b0);
        clear_mem();
        @(negedge clk);
        strip_lead = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = (mem_we === 1'b1);
            sample_write("t6_prefix");
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL t6_first_write got none in %0d cycles required a write", n);
        end
        @(negedge clk);
        sample_write("t6_prefix");
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_we, busy, done, error, taps_idx} !== '0) begin
            errors++;
            $display("FAIL t6_reset_outputs got addr=%h we=%b busy=%b done=%b err=%b idx=%0d required all 0",
                     mem_addr, mem_we, busy, done, error, taps_idx);
        end
        wr_after = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_we !== 1'b0) wr_after++;
        end
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mem_we !== 1'b0) wr_after++;
        end
        checks++;
        if (wr_after != 0) begin
            errors++;
            $display("FAIL t6_writes_after_reset got %0d required 0", wr_after);
        end
        expect_writes(1'b0, 1'b0);
        clear_mem();
        run("t6_rerun", 1'b0, 1'b0, 3'd3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mode0_fixed();
        test_mode1_strip();
        test_mode1_all_space();
        test_all_taps();
        test_no_match();
        test_zero_seed();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
